// File: rtl/secded13_pkg.sv
// Shared constants, bit placement and reference functions for the 13-bit SECDED (8 data + 5 check bits) code.
package secded13_pkg;

    localparam int DATA_W = 8;
    localparam int CODE_W = 13;

    localparam int P1_POS = 1;
    localparam int P2_POS = 2;
    localparam int P4_POS = 4;
    localparam int P8_POS = 8;

    // Hamming position of data bit d[i]
    localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12};

    // Returns {p8, p4, p2, p1}
    function automatic logic [3:0] secded13_parity_f(input logic [DATA_W-1:0] d);
        logic [3:0] p_s;
        p_s[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        p_s[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        p_s[2] = d[1] ^ d[2] ^ d[3] ^ d[7];
        p_s[3] = d[4] ^ d[5] ^ d[6] ^ d[7];
        return p_s;
    endfunction

    // Full clean codeword, cw[0] = even overall parity over cw[12:1]
    function automatic logic [CODE_W-1:0] secded13_encode_f(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] cw_s;
        logic [3:0]        p_s;
        p_s          = secded13_parity_f(d);
        cw_s         = {CODE_W{1'b0}};
        cw_s[P1_POS] = p_s[0];
        cw_s[P2_POS] = p_s[1];
        cw_s[P4_POS] = p_s[2];
        cw_s[P8_POS] = p_s[3];
        for (int i = 0; i < DATA_W; i++) begin
            cw_s[DATA_POS[i]] = d[i];
        end
        cw_s[0] = ^cw_s[CODE_W-1:1];
        return cw_s;
    endfunction

endpackage

// File: rtl/large_xor.sv
// Wide bitwise XOR block, used to apply the error-injection mask.
module large_xor #(
    parameter int W = 13
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = a ^ b;

endmodule

// File: rtl/secded13_parity.sv
// Combinational Hamming parity generator: data byte to p1/p2/p4/p8.
module secded13_parity
    import secded13_pkg::*;
(
    input  logic [DATA_W-1:0] d,
    output logic              p1,
    output logic              p2,
    output logic              p4,
    output logic              p8
);

    logic [3:0] par_s;

    assign par_s            = secded13_parity_f(d);
    assign {p8, p4, p2, p1} = par_s;

endmodule

// File: rtl/secded_enc13_pipe.sv
// Two-stage valid/ready SECDED encoder: S1 registers data+parity+mask, S2 registers the (optionally corrupted) codeword.
module secded_enc13_pipe
    import secded13_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CODE_W-1:0] in_err_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              inj_flag
);

    logic              s1_v_r;
    logic              s2_v_r;
    logic [DATA_W-1:0] s1_data_r;
    logic [3:0]        s1_par_r;
    logic [CODE_W-1:0] s1_mask_r;
    logic [CODE_W-1:0] out_code_r;
    logic              inj_flag_r;
    logic [CNT_W-1:0]  word_cnt_r;

    logic              s1_load_s;
    logic              s2_load_s;
    logic [3:0]        par_s;
    logic [CODE_W-1:1] body_s;
    logic [CODE_W-1:0] clean_s;
    logic [CODE_W-1:0] coded_s;

    // A stage may load when empty or when its word leaves this cycle
    assign s2_load_s = !s2_v_r || out_ready;
    assign s1_load_s = !s1_v_r || s2_load_s;

    assign in_ready  = s1_load_s;
    assign out_valid = s2_v_r;
    assign out_code  = out_code_r;
    assign inj_flag  = inj_flag_r;
    assign word_cnt  = word_cnt_r;

    secded13_parity u_parity (
        .d  (in_data),
        .p1 (par_s[0]),
        .p2 (par_s[1]),
        .p4 (par_s[2]),
        .p8 (par_s[3])
    );

    // Place registered parity and data bits at their Hamming positions
    always_comb begin
        body_s         = {(CODE_W-1){1'b0}};
        body_s[P1_POS] = s1_par_r[0];
        body_s[P2_POS] = s1_par_r[1];
        body_s[P4_POS] = s1_par_r[2];
        body_s[P8_POS] = s1_par_r[3];
        for (int i = 0; i < DATA_W; i++) begin
            body_s[DATA_POS[i]] = s1_data_r[i];
        end
    end

    // Overall parity is taken before the mask so the mask bit count equals the error count
    assign clean_s = {body_s, ^body_s};

    large_xor #(.W(CODE_W)) u_mask_xor (
        .a (clean_s),
        .b (s1_mask_r),
        .y (coded_s)
    );

    // Pipeline registers and delivered-word counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_r     <= 1'b0;
            s2_v_r     <= 1'b0;
            s1_data_r  <= {DATA_W{1'b0}};
            s1_par_r   <= 4'b0000;
            s1_mask_r  <= {CODE_W{1'b0}};
            out_code_r <= {CODE_W{1'b0}};
            inj_flag_r <= 1'b0;
            word_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (s1_load_s) begin
                s1_v_r <= in_valid;
                if (in_valid) begin
                    s1_data_r <= in_data;
                    s1_par_r  <= par_s;
                    s1_mask_r <= in_err_mask;
                end
            end
            if (s2_load_s) begin
                s2_v_r <= s1_v_r;
                if (s1_v_r) begin
                    out_code_r <= coded_s;
                    inj_flag_r <= |s1_mask_r;
                end
            end
            if (s2_v_r && out_ready) begin
                word_cnt_r <= word_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_secded_enc13_pipe.sv
// Directed + scoreboard bench for secded_enc13_pipe; a CNT_W=4 twin shares the stimulus for the wrap check.
`timescale 1ns/1ps
module tb_secded_enc13_pipe;

    localparam int DPOS [8] = '{3, 5, 6, 7, 9, 10, 11, 12};

    typedef struct packed {
        logic [7:0]  d;
        logic [12:0] m;
        logic [12:0] code;
        logic        inj;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready;
    logic [7:0]  in_data;
    logic [12:0] in_err_mask;
    logic        in_ready, out_valid, inj_flag;
    logic [12:0] out_code;
    logic [15:0] word_cnt;
    logic        in_ready4, out_valid4, inj4;
    logic [12:0] out_code4;
    logic [3:0]  word_cnt4;

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   exp_cnt   = 0;
    exp_t exp_q[$];
    logic        prev_stall = 1'b0;
    logic [12:0] prev_code;
    logic        prev_inj;
    bit          rnd_done;

    secded_enc13_pipe #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_err_mask(in_err_mask), .out_valid(out_valid),
        .out_ready(out_ready), .out_code(out_code), .word_cnt(word_cnt), .inj_flag(inj_flag)
    );

    secded_enc13_pipe #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_err_mask(in_err_mask), .out_valid(out_valid4),
        .out_ready(out_ready), .out_code(out_code4), .word_cnt(word_cnt4), .inj_flag(inj4)
    );

    always #5 clk = ~clk;

    // Independent model: place data, then each parity bit covers positions with its index bit set
    function automatic logic [12:0] enc(input logic [7:0] d);
        logic [12:0] c;
        logic        p;
        c = 13'h0000;
        for (int i = 0; i < 8; i++) c[DPOS[i]] = d[i];
        for (int k = 0; k < 4; k++) begin
            p = 1'b0;
            for (int i = 1; i < 13; i++) if (i[k]) p ^= c[i];
            c[1 << k] = p;
        end
        c[0] = ^c[12:1];
        return c;
    endfunction

    // Reference decoder: returns {double_error, corrected_data}
    function automatic logic [8:0] dec(input logic [12:0] c);
        int          s;
        logic [12:0] cc;
        logic        dbl;
        logic [7:0]  d;
        s = 0; cc = c; dbl = 1'b0;
        for (int i = 1; i < 13; i++) if (c[i]) s ^= i;
        if (^c) begin
            if (s < 13) cc[s] = ~cc[s];
        end else if (s != 0) begin
            dbl = 1'b1;
        end
        for (int i = 0; i < 8; i++) d[i] = cc[DPOS[i]];
        return {dbl, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total_cnt++;
        assert (obs === want) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    endtask

    task automatic timeout_fail(input string tag);
        total_cnt++;
        $error("FAIL %s: observed timeout expected completion", tag);
    endtask

    task automatic send(input logic [7:0] d, input logic [12:0] m);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1; in_data = d; in_err_mask = m;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        if (!acc) timeout_fail("send_accept");
    endtask

    task automatic expect_out(input string tag, input logic [12:0] code, input logic inj);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                seen = 1'b1;
                chk(tag, out_code, code);
                chk({tag, "_inj"}, inj_flag, inj);
            end
        end
        if (!seen) timeout_fail(tag);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !out_valid;
        end
        if (!done) timeout_fail("drain");
        @(posedge clk); #1;
    endtask

    // Scoreboard: negedge sees the handshake that the next rising edge will complete
    always @(negedge clk) begin
        exp_t e;
        logic [8:0] r;
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt    = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_code", out_code, prev_code);
                chk("stall_inj", inj_flag, prev_inj);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", out_code, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("code", out_code, e.code);
                    chk("inj", inj_flag, e.inj);
                    chk("w4_code", {out_valid4, inj4, out_code4}, {1'b1, e.inj, e.code});
                    if (e.m == 13'h0000) chk("even_parity", ^out_code, 0);
                    r = dec(out_code);
                    if ($countones(e.m) < 2) begin
                        chk("dec_data", r[7:0], e.d);
                        chk("dec_no_dbl", r[8], 0);
                    end else if ($countones(e.m) == 2) begin
                        chk("dec_dbl", r[8], 1);
                    end
                end
                exp_cnt++;
            end
            if (in_valid && in_ready)
                exp_q.push_back('{in_data, in_err_mask, enc(in_data) ^ in_err_mask, |in_err_mask});
            prev_stall = out_valid && !out_ready;
            prev_code  = out_code;
            prev_inj   = inj_flag;
        end
    end

    initial begin
        int gap, b1;
        logic [12:0] m;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_err_mask = 13'h0000; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_code", out_code, 0);
        chk("rst_inj", inj_flag, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_in_ready", {in_ready, in_ready4}, 2'b11);

        // Back-to-back clean words, exact two-cycle latency
        @(posedge clk); #1 in_valid = 1'b1; in_data = 8'h00;
        @(posedge clk); #1 in_data = 8'hFF;
        @(negedge clk); chk("lat_not_yet", out_valid, 0);
        @(posedge clk); #1 in_data = 8'h01;
        @(negedge clk); chk("lat_valid", out_valid, 1); chk("cw_00", out_code, 13'h0000);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk); chk("cw_ff", out_code, 13'h1EEE);
        @(posedge clk);
        @(negedge clk); chk("cw_01", out_code, 13'h000F);
        @(posedge clk);
        @(negedge clk); chk("cnt_3", word_cnt, 3);
        @(posedge clk); #1;

        // Fault injection
        send(8'hFF, 13'h0001);
        send(8'hFF, 13'h1001);
        in_valid = 1'b0;
        expect_out("inj_single", 13'h1EEF, 1'b1);
        expect_out("inj_double", 13'h0EEF, 1'b1);
        drain();

        // Backpressure: two words fill the pipe, third must wait
        out_ready = 1'b0;
        send(8'h11, 13'h0000);
        send(8'h22, 13'h0000);
        in_valid = 1'b1; in_data = 8'h33; in_err_mask = 13'h0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_head", out_code, enc(8'h11));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk); chk("bp_release_ready", in_ready, 1);
        @(posedge clk); #1;
        send(8'h44, 13'h0000);
        in_valid = 1'b0;
        drain();
        chk("bp_count", word_cnt, exp_cnt);

        // Exhaustive data with random input gaps and output stalls
        rnd_done = 1'b0;
        fork
            begin
                for (int d = 0; d < 256; d++) begin
                    gap = $urandom_range(0, 2);
                    if (gap != 0) begin
                        in_valid = 1'b0;
                        repeat (gap) @(posedge clk);
                        #1;
                    end
                    send(d[7:0], 13'h0000);
                end
                in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();
        chk("exh_count", word_cnt, exp_cnt);

        // Random single/double injected errors through the reference decoder
        for (int k = 0; k < 24; k++) begin
            b1 = $urandom_range(0, 12);
            m  = 13'h0001 << b1;
            if ($urandom_range(0, 1) != 0) m |= 13'h0001 << ((b1 + $urandom_range(1, 12)) % 13);
            send($urandom_range(0, 255), m);
        end
        in_valid = 1'b0;
        drain();

        // Reset with both stages full
        out_ready = 1'b0;
        send(8'hA5, 13'h0000);
        send(8'h3C, 13'h0003);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_word_cnt", word_cnt, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(posedge clk); #1 out_ready = 1'b1;

        // 17 transfers: 16-bit counter reads 17, 4-bit twin wraps to 1
        for (int k = 0; k < 17; k++) send(8'(k * 37 + 5), 13'h0000);
        in_valid = 1'b0;
        drain();
        chk("wrap_cnt16", word_cnt, 17);
        chk("wrap_cnt4", word_cnt4, 1);
        chk("wrap_model", word_cnt, exp_cnt);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
